pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the CPU front end.
- Sits directly downstream of the 4-way 32-bit next-PC mux. It consumes the mux output as `npc` and feeds `pc4` back as the mux's sequential input (select 00).
- Drives a ready-based instruction-memory handshake.
- Holds the fetched instruction in a one-entry valid/ready output buffer for the decode stage, with stall, flush and wait-timeout handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] are ignored and taken as 00.
- WAIT_LIMIT, 16, number of consecutive unanswered request cycles that forces the error state; legal range 2..255.

Ports:
- Clk  input  1  system clock, rising edge.
- Clrn  input  1  asynchronous active-low reset.
- npc  input  32  next-PC from the next-PC mux.
- flush  input  1  redirect: load `npc` immediately and discard in-flight work.
- pc  output  32  current fetch address.
- pc4  output  32  `pc` + 4, combinational, feeds the next-PC mux sequential input.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  equals `pc`.
- imem_ready  input  1  memory returns `imem_rdata` this cycle; meaningful only while `imem_req`=1.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  output buffer holds an instruction.
- if_ready  input  1  decode accepts the buffer this cycle; `if_ready`=0 means stall.
- if_inst  output  32  buffered instruction.
- if_pc  output  32  address of `if_inst`.
- imem_err  output  1  sticky timeout flag.

Behaviour:
- Clock and reset:
  - One clock domain, `Clk`; all state updates on the rising edge.
  - Reset is asynchronous and active-low on `Clrn`.
- Reset values (`Clrn`=0):
  - `pc` = {RESET_PC[31:2],2'b00}.
  - State = BOOT.
  - `if_valid`=0, `if_inst`=0, `if_pc`=0, `imem_err`=0, wait counter=0.
  - `imem_req`=0 combinationally.
- Reset mid-fetch: an asserted `Clrn` aborts any fetch instantly; no partial buffer update.
- States:
  - BOOT: `imem_req`=0. Always moves to FETCH on the next edge, giving one idle cycle after reset release.
  - FETCH: `imem_req` = (!`if_valid` | `if_ready`) & !`flush`, combinational. `imem_addr`=`pc`.
  - ERR: terminal. `imem_req`=0, `imem_err`=1. `if_valid` still drains normally via `if_ready`. Flush is ignored. Only reset exits ERR.
- Fetch completion (FETCH, `imem_req`=1, `imem_ready`=1, `flush`=0), all on the same edge:
  - `if_inst`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1.
  - `pc`<={`npc`[31:2],2'b00}; the wait counter clears.
  - Latency: `imem_ready` at cycle N gives `if_valid`=1 at N+1, and the new `imem_addr` at N+1.
  - Back-to-back: with memory answering every cycle and `if_ready`=1, one instruction per cycle.
- Buffer drain: `if_valid`&`if_ready` with no completion in the same cycle gives `if_valid`<=0. Drain and completion in the same cycle replaces the entry; `if_valid` stays 1.
- Stall: `if_valid`=1 and `if_ready`=0 gives `imem_req`=0. `pc` and the buffer hold unchanged, and the wait counter does not count.
- Address stability: `pc` changes only on completion, flush or reset. Memory must tolerate an address change while `imem_req` is high only after flush.
- Flush (FETCH or BOOT, `flush`=1):
  - `pc`<={`npc`[31:2],2'b00}, `if_valid`<=0, wait counter<=0.
  - Any same-cycle `imem_ready`/`imem_rdata` is discarded.
  - BOOT still advances to FETCH.
  - Flush with `if_ready`=1 gives no acceptance: the entry is dropped.
- Timeout:
  - The wait counter increments each cycle with `imem_req`=1 and `imem_ready`=0.
  - On reaching WAIT_LIMIT, go to ERR on that edge and set `imem_err`<=1.
- Arithmetic: `pc4` = `pc`+32'd4, modulo 2^32 (32'hFFFF_FFFC gives 0). No overflow flag.

Test Plan:
- Reset release, memory always ready with rdata=addr^32'hA5A5_0000, `npc`=`pc4`, `if_ready`=1 -> `imem_req`=0 for one cycle. Then `if_pc` sequence 0,4,8,C on consecutive cycles with matching `if_inst`; `pc4`=`pc`+4.
- Stall: hold `if_ready`=0 for 3 cycles after `if_inst` from 0x8 -> `imem_req`=0, `pc`=0xC and `if_inst` stable. Release -> fetch of 0xC resumes next cycle with no duplicate or lost word.
- Flush with `npc`=0x0000_0100 in the same cycle as `imem_ready`=1 -> that word is discarded, `if_valid`=0 next cycle, `imem_addr`=0x100, next `if_pc`=0x100.
- Misaligned `npc`=0x0000_0203 on completion -> `pc`=0x200. Wrap case: `pc`=0xFFFF_FFFC -> `pc4`=0.
- With WAIT_LIMIT=16 and `imem_ready` held 0 -> after 16 request cycles `imem_err`=1 and `imem_req`=0. A later `imem_ready` or `flush` is ignored; the held `if_valid` entry still drains.
- Assert `Clrn`=0 asynchronously mid-wait (between clock edges) -> `imem_req`, `if_valid` and `imem_err` drop immediately, and `pc`=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer: drives a ready-based
// instruction-memory handshake and holds one fetched word for decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] npc,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        imem_err
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  WAIT_LIM   = 8'(WAIT_LIMIT);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_inst_q;
  logic [31:0] if_pc_q;
  logic        if_valid_q;
  logic        err_q;
  logic [7:0]  wait_q;

  logic [31:0] pc_d;
  logic [7:0]  wait_d;
  logic        req;
  logic        complete;
  logic        drain;

  // A full buffer that decode is not taking blocks new requests.
  assign req      = (state_q == S_FETCH) && (!if_valid_q || if_ready) && !flush;
  assign complete = req && imem_ready;
  assign drain    = if_valid_q && if_ready;
  assign pc_d     = word_align(npc);
  assign wait_d   = wait_q + 8'd1;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC_A;
      if_inst_q  <= 32'h0;
      if_pc_q    <= 32'h0;
      if_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= 8'h0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          if (flush) begin
            pc_q       <= pc_d;
            if_valid_q <= 1'b0;
            wait_q     <= 8'h0;
          end else if (drain) begin
            if_valid_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (flush) begin
            // Redirect wins over any same-cycle memory response or acceptance.
            pc_q       <= pc_d;
            if_valid_q <= 1'b0;
            wait_q     <= 8'h0;
          end else if (complete) begin
            if_inst_q  <= imem_rdata;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_d;
            wait_q     <= 8'h0;
          end else begin
            if (drain) begin
              if_valid_q <= 1'b0;
            end
            if (req) begin
              wait_q <= wait_d;
              if (wait_d == WAIT_LIM) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end
            end
          end
        end
        S_ERR: begin
          if (drain) begin
            if_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign imem_err  = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: a transaction-level model predicts
// every word decode should accept; a negedge monitor compares what the DUT hands over.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LIMIT  = 16;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] pc, pc4, imem_addr, if_inst, if_pc;
  logic        imem_req, if_valid, imem_err;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_ready = 1'b0;

  pc_fetch_unit #(.RESET_PC(RST_PC), .WAIT_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Clrn(Clrn), .npc(npc), .flush(flush), .pc(pc), .pc4(pc4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .imem_err(imem_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ent_t;

  // Reference model: 0 = idle after reset, 1 = fetching, 2 = dead after timeout
  int          m_st;
  logic [31:0] m_pc;
  ent_t        m_buf[$];
  int          m_wait;
  bit          m_err;
  ent_t        exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return (m_st == 1) && (m_buf.size() == 0 || if_ready) && !flush;
  endfunction

  function automatic void model_reset();
    m_st   = 0;
    m_pc   = {RST_PC[31:2], 2'b00};
    m_buf.delete();
    m_wait = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step();
    bit   rq;
    ent_t e;
    rq = m_req();
    if (m_st == 2) begin
      if (m_buf.size() != 0 && if_ready) void'(m_buf.pop_front());
    end else if (flush) begin
      m_pc = {npc[31:2], 2'b00};
      m_buf.delete();
      m_wait = 0;
      m_st = 1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else begin
      if (m_buf.size() != 0 && if_ready) void'(m_buf.pop_front());
      if (rq && imem_ready) begin
        e.addr = m_pc;
        e.inst = imem_rdata;
        m_buf.push_back(e);
        m_pc = {npc[31:2], 2'b00};
        m_wait = 0;
      end else if (rq) begin
        m_wait++;
        if (m_wait >= LIMIT) begin
          m_st = 2;
          m_err = 1'b1;
        end
      end
    end
  endfunction

  // One clock of stimulus; the expected acceptance (if any) is queued as it is issued.
  task automatic cycle(input bit rdy, input bit irdy, input bit fl, input logic [31:0] np);
    imem_ready = rdy;
    imem_rdata = $urandom;
    if_ready   = irdy;
    flush      = fl;
    npc        = np;
    if (Clrn && m_buf.size() != 0 && irdy && !(fl && m_st != 2))
      exp_q.push_back(m_buf[0]);
    @(posedge Clk);
    if (Clrn) model_step();
    #1;
  endtask

  task automatic rnd(input int p_rdy, input int p_ir, input int p_fl);
    int          r;
    logic [31:0] np;
    r = $urandom_range(0, 99);
    if (r < 80)      np = m_pc + 32'd4;
    else if (r < 95) np = $urandom;
    else             np = 32'hFFFF_FFFC;
    cycle($urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_ir,
          $urandom_range(0, 99) < p_fl, np);
  endtask

  task automatic async_reset();
    #2;
    Clrn = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_imem_err", 32'(imem_err), 32'h0);
    chk("rst_pc", pc, {RST_PC[31:2], 2'b00});
    @(posedge Clk);
    #1;
    Clrn = 1'b1;
  endtask

  // Monitor: compares visible state each cycle and pops the scoreboard on every acceptance.
  always @(negedge Clk) begin
    ent_t e;
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    chk("if_valid", 32'(if_valid), 32'(m_buf.size() != 0));
    chk("imem_err", 32'(imem_err), 32'(m_err));
    if (if_valid && if_ready && !(flush && !imem_err)) begin
      if (exp_q.size() == 0) begin
        chk("accept_unexpected", if_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("accept_pc", if_pc, e.addr);
        chk("accept_inst", if_inst, e.inst);
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("reset_if_inst", if_inst, 32'h0);
    chk("reset_if_pc", if_pc, 32'h0);
    chk("reset_pc", pc, 32'h0);
    @(posedge Clk);
    #1;
    Clrn = 1'b1;

    // Sequential fetch, memory always ready, decode always taking.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    // Decode stall then release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    // Flush colliding with a memory response.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    chk("flush_if_valid", 32'(if_valid), 32'h0);
    chk("flush_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    // Misaligned redirect and address wrap.
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_0203);
    chk("misaligned_pc", pc, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0000_0000);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_0000);
    chk("wrap_pc", pc, 32'h0000_0000);

    for (int i = 0; i < 1500; i++) rnd(70, 70, 5);

    // Reset asynchronously while a request is waiting.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, m_pc + 32'd4);
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, m_pc + 32'd4);

    // Timeout into the terminal error state, then hammer it.
    cycle(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, m_pc + 32'd4);
    chk("timeout_err", 32'(imem_err), 32'h1);
    chk("timeout_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 30; i++) rnd(80, 50, 30);
    chk("err_sticky", 32'(imem_err), 32'h1);

    async_reset();
    for (int i = 0; i < 200; i++) rnd(70, 70, 5);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
